ek_loader: RTL and testbench

EK_LOADER -- requirements
Module: ek_loader

---
 rtl/ek_loader.sv | 140 ++++++++++++++
 tb/tb_ek_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ek_loader.sv
// Encapsulation-key loader: collects EK_BYTES bytes into an array, checks that every
// 12-bit coefficient is below Q and that the key length is right, then holds the key.
module ek_loader #(
    parameter int EK_BYTES   = 1184,
    parameter int POLY_BYTES = 1152,
    parameter int Q          = 3329
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic [7:0] ek [EK_BYTES-1:0],
    output logic       ek_valid,
    output logic       ek_ok,
    output logic       len_err,
    output logic       mod_err,
    output logic       start_out,
    input  logic       ek_ack
);

    localparam logic [0:0]  ST_RECV  = 1'b0;
    localparam logic [0:0]  ST_HOLD  = 1'b1;
    localparam logic [10:0] LAST_IDX = 11'(EK_BYTES - 1);
    localparam logic [10:0] POLY_LIM = 11'(POLY_BYTES);
    localparam logic [11:0] Q_L      = 12'(Q);

    logic [0:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  ph_q, ph_d;
    logic [7:0]  b0_q, b0_d;
    logic [7:0]  b1_q, b1_d;
    logic        ek_valid_q, ek_valid_d;
    logic        ek_ok_q, ek_ok_d;
    logic        len_err_q, len_err_d;
    logic        mod_err_q, mod_err_d;
    logic        start_q, start_d;
    logic [7:0]  ek_q [EK_BYTES-1:0];

    logic        accept;
    logic        at_end;
    logic [11:0] d1;
    logic [11:0] d2;

    assign in_ready = (state_q == ST_RECV);
    assign accept   = in_valid && in_ready;
    assign at_end   = (cnt_q == LAST_IDX);
    // Coefficient pair of the current group, completed by the byte arriving now.
    assign d1       = {b1_q[3:0], b0_q};
    assign d2       = {in_byte, b1_q[7:4]};

    always_comb begin
        // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        ek_valid_d = ek_valid_q;
        ek_ok_d    = ek_ok_q;
        len_err_d  = len_err_q;
        mod_err_d  = mod_err_q;
        start_d    = 1'b0;

        if (state_q == ST_RECV) begin
            if (accept) begin
                cnt_d = cnt_q + 11'd1;
                case (ph_q)
                    2'd0:    begin b0_d = in_byte; ph_d = 2'd1; end
                    2'd1:    begin b1_d = in_byte; ph_d = 2'd2; end
                    default: begin
                        ph_d = 2'd0;
                        if (cnt_q < POLY_LIM && (d1 >= Q_L || d2 >= Q_L)) begin
                            mod_err_d = 1'b1;
                        end
                    end
                endcase
                if (in_last || at_end) begin
                    if (in_last != at_end) begin
                        len_err_d = 1'b1;
                    end
                    state_d    = ST_HOLD;
                    ek_valid_d = 1'b1;
                    ek_ok_d    = !len_err_d && !mod_err_d;
                    start_d    = !len_err_d && !mod_err_d;
                end
            end
        end else if (ek_ack) begin
            state_d    = ST_RECV;
            cnt_d      = '0;
            ph_d       = '0;
            ek_valid_d = 1'b0;
            ek_ok_d    = 1'b0;
            len_err_d  = 1'b0;
            mod_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RECV;
            cnt_q      <= '0;
            ph_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            ek_valid_q <= 1'b0;
            ek_ok_q    <= 1'b0;
            len_err_q  <= 1'b0;
            mod_err_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            ek_valid_q <= ek_valid_d;
            ek_ok_q    <= ek_ok_d;
            len_err_q  <= len_err_d;
            mod_err_q  <= mod_err_d;
            start_q    <= start_d;
        end
    end

    // NOTE: the key storage has no reset; a new key always overwrites from index 0 and cnt gates validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            ek_q[cnt_q] <= in_byte;
        end
    end

    assign ek        = ek_q;
    assign ek_valid  = ek_valid_q;
    assign ek_ok     = ek_ok_q;
    assign len_err   = len_err_q;
    assign mod_err   = mod_err_q;
    assign start_out = start_q;

endmodule

// File: tb/tb_ek_loader.sv
// Directed bench for ek_loader: table of key patterns with expected status, plus
// hand-written sequences for HOLD behaviour, ack handling and asynchronous reset.
module tb_ek_loader;

    localparam int EKB = 1184;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       in_last;
    logic [7:0] ek [EKB-1:0];
    logic       ek_valid;
    logic       ek_ok;
    logic       len_err;
    logic       mod_err;
    logic       start_out;
    logic       ek_ack;

    ek_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .ek        (ek),
        .ek_valid  (ek_valid),
        .ek_ok     (ek_ok),
        .len_err   (len_err),
        .mod_err   (mod_err),
        .start_out (start_out),
        .ek_ack    (ek_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] key [EKB];

    typedef struct {
        string      name;
        int         n;
        int         last_at;
        int         p0;
        logic [7:0] v0;
        int         p1;
        logic [7:0] v1;
        int         p2;
        logic [7:0] v2;
        logic       ok;
        logic       le;
        logic       me;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_key(input int p0, input logic [7:0] v0, input int p1, input logic [7:0] v1,
                             input int p2, input logic [7:0] v2);
        for (int i = 0; i < EKB; i++) key[i] = 8'h00;
        if (p0 >= 0) key[p0] = v0;
        if (p1 >= 0) key[p1] = v1;
        if (p2 >= 0) key[p2] = v2;
    endtask

    // Streams key[0..n-1] one byte per cycle; returns at the negedge after the last accept.
    task automatic send(input int n, input int last_at, input int ack_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = key[i];
            in_last  = (i == last_at);
            ek_ack   = (i == ack_at);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        ek_ack   = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic check_done(input string nm, input logic ok, input logic le, input logic me);
        check({nm, ".ek_valid"}, ek_valid, 1'b1);
        check({nm, ".ek_ok"}, ek_ok, ok);
        check({nm, ".len_err"}, len_err, le);
        check({nm, ".mod_err"}, mod_err, me);
        check({nm, ".start_out"}, start_out, ok);
        check({nm, ".in_ready"}, in_ready, 1'b0);
        @(negedge clk);
        check({nm, ".start_pulse_end"}, start_out, 1'b0);
        check({nm, ".ek_valid_held"}, ek_valid, 1'b1);
    endtask

    task automatic do_ack(input string nm);
        ek_ack = 1'b1;
        @(negedge clk);
        ek_ack = 1'b0;
        check({nm, ".ack_valid"}, ek_valid, 1'b0);
        check({nm, ".ack_ready"}, in_ready, 1'b1);
        check({nm, ".ack_len"}, len_err, 1'b0);
        check({nm, ".ack_mod"}, mod_err, 1'b0);
    endtask

    task automatic check_idle(input string nm);
        check({nm, ".ek_valid"}, ek_valid, 1'b0);
        check({nm, ".ek_ok"}, ek_ok, 1'b0);
        check({nm, ".len_err"}, len_err, 1'b0);
        check({nm, ".mod_err"}, mod_err, 1'b0);
        check({nm, ".start_out"}, start_out, 1'b0);
        check({nm, ".in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{"zeros",        1184, 1183,   -1, 8'h00,   -1, 8'h00,   -1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"d1_3328",      1184, 1183,    1, 8'h0D,   -1, 8'h00,   -1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"d1_3329",      1184, 1183,    0, 8'h01,    1, 8'h0D,   -1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{"d2_3329",      1184, 1183,    4, 8'h10,    5, 8'hD0,   -1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{"d2_3328",      1184, 1183,    5, 8'hD0,   -1, 8'h00,   -1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"rho_ff",       1184, 1183, 1160, 8'hFF,   -1, 8'h00,   -1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"last_group",   1184, 1183, 1149, 8'hFF, 1150, 8'hFF,   -1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"rho_first",    1184, 1183, 1152, 8'hFF, 1153, 8'hFF, 1154, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"early_last10",   11,   10,    2, 8'h7E,   -1, 8'h00,   -1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{"no_last",      1184,   -1,   -1, 8'h00,   -1, 8'h00,   -1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{"partial_grp",     5,    4,    3, 8'hFF,    4, 8'hFF,   -1, 8'h00, 1'b0, 1'b1, 1'b0};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_last  = 1'b0;
        ek_ack   = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            build_key(vecs[k].p0, vecs[k].v0, vecs[k].p1, vecs[k].v1, vecs[k].p2, vecs[k].v2);
            send(vecs[k].n, vecs[k].last_at, -1);
            check_done(vecs[k].name, vecs[k].ok, vecs[k].le, vecs[k].me);
            if (vecs[k].p0 >= 0) check({vecs[k].name, ".ek_p0"}, ek[vecs[k].p0], vecs[k].v0);
            do_ack(vecs[k].name);
        end

        // Full group closed by an early in_last is still checked.
        build_key(3, 8'hFF, 4, 8'hFF, -1, 8'h00);
        send(6, 5, -1);
        check_done("early_full_grp", 1'b0, 1'b1, 1'b1);
        do_ack("early_full_grp");

        // ek_ack while receiving has no effect.
        build_key(700, 8'h33, -1, 8'h00, -1, 8'h00);
        send(1184, 1183, 600);
        check_done("ack_in_recv", 1'b1, 1'b0, 1'b0);
        check("ack_in_recv.ek700", ek[700], 8'h33);
        do_ack("ack_in_recv");

        // HOLD ignores incoming bytes; ack returns to RECV and the next byte lands at ek[0].
        build_key(0, 8'h11, 1183, 8'h22, -1, 8'h00);
        send(1184, 1183, -1);
        check_done("hold", 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        in_last  = 1'b1;
        repeat (5) @(negedge clk);
        check("hold.ek0", ek[0], 8'h11);
        check("hold.ek1183", ek[1183], 8'h22);
        check("hold.valid", ek_valid, 1'b1);
        check("hold.ok", ek_ok, 1'b1);
        in_last = 1'b0;
        ek_ack  = 1'b1;
        @(negedge clk);
        ek_ack  = 1'b0;
        in_byte = 8'h5A;
        check("hold.ack_valid", ek_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold.new_ek0", ek[0], 8'h5A);
        check("hold.kept_ek1183", ek[1183], 8'h22);

        // Reset while holding an erroneous key clears the status at once.
        #2 rst = 1'b0;
        #1 check_idle("rst_idle");
        @(negedge clk);
        rst = 1'b1;
        build_key(0, 8'hFF, 1, 8'hFF, -1, 8'h00);
        send(6, 5, -1);
        check_done("pre_rst_hold", 1'b0, 1'b1, 1'b1);
        #2 rst = 1'b0;
        #1 check_idle("rst_in_hold");
        @(negedge clk);
        rst = 1'b1;

        // Reset after byte 500 of a bad key; the next valid key starts at ek[0].
        send(501, -1, -1);
        #2 rst = 1'b0;
        #1 check_idle("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        build_key(0, 8'h42, 1183, 8'h99, -1, 8'h00);
        send(1184, 1183, -1);
        check_done("after_rst", 1'b1, 1'b0, 1'b0);
        check("after_rst.ek0", ek[0], 8'h42);
        check("after_rst.ek1183", ek[1183], 8'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
